// File: rtl/sha256_compress_core.sv
// SHA-256 compression core: one 512-bit block per request, UNROLL rounds per clock.
// Optional SHA-224 support when SHA256_SHA224_EN is defined (adds the mode224 input).
module sha256_compress_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         first,
  input  logic [511:0] block,
`ifdef SHA256_SHA224_EN
  input  logic         mode224,
`endif
  output logic         ready,
  output logic         done,
  output logic [255:0] digest
);

  localparam int unsigned CNT_W    = 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(64 - UNROLL);

  localparam logic [255:0] IV256_FLAT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224_FLAT =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha256_compress_core: UNROLL must be 1, 2 or 4");
  end

  // Index 0 is word a / H0 / W[t]; higher indices follow in order.
  typedef logic [7:0][31:0]  word8_t;
  typedef logic [15:0][31:0] word16_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  function automatic word8_t to_words(input logic [255:0] v);
    word8_t w;
    for (int i = 0; i < 8; i++) w[i] = v[255-32*i -: 32];
    return w;
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word8_t           st_q, st_d;
  word16_t          w_q, w_d;
  word8_t           init_q, init_d;
  word8_t           chain_q, chain_d;
  logic [255:0]     digest_q, digest_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             m224_q, m224_d;
  logic             run_q, run_d;
  logic             m224_in;
  word8_t           rnd_st;
  word16_t          rnd_w;
  word8_t           sum;

`ifdef SHA256_SHA224_EN
  assign m224_in = mode224;
`else
  assign m224_in = 1'b0;
`endif

  // UNROLL chained rounds plus rolling message-schedule update.
  always_comb begin : round_unroll
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] wn;
    rnd_st = st_q;
    rnd_w  = w_q;
    t1     = '0;
    t2     = '0;
    wn     = '0;
    for (int unsigned r = 0; r < UNROLL; r++) begin
      t1 = rnd_st[7] + bsig1(rnd_st[4]) + ch(rnd_st[4], rnd_st[5], rnd_st[6])
         + K_ROM[cnt_q + CNT_W'(r)] + rnd_w[0];
      t2 = bsig0(rnd_st[0]) + maj(rnd_st[0], rnd_st[1], rnd_st[2]);
      wn = ssig1(rnd_w[14]) + rnd_w[9] + ssig0(rnd_w[1]) + rnd_w[0];
      rnd_st    = {rnd_st[6:0], t1 + t2};
      rnd_st[4] = rnd_st[4] + t1;
      rnd_w     = {wn, rnd_w[15:1]};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin : next_state
    state_d  = state_q;
    cnt_d    = cnt_q;
    st_d     = st_q;
    w_d      = w_q;
    init_d   = init_q;
    chain_d  = chain_q;
    digest_d = digest_q;
    done_d   = 1'b0;
    m224_d   = m224_q;
    run_d    = 1'b1;
    for (int i = 0; i < 8; i++) sum[i] = init_q[i] + st_q[i];

    unique case (state_q)
      S_IDLE: begin
        if (start && run_q) begin
          state_d = S_ROUND;
          cnt_d   = '0;
          for (int i = 0; i < 16; i++) w_d[i] = block[511-32*i -: 32];
          if (first) init_d = m224_in ? to_words(IV224_FLAT) : to_words(IV256_FLAT);
          else       init_d = chain_q;
          st_d   = init_d;
          m224_d = m224_in;
        end
      end
      S_ROUND: begin
        st_d  = rnd_st;
        w_d   = rnd_w;
        cnt_d = cnt_q + CNT_W'(UNROLL);
        if (cnt_q == CNT_LAST) state_d = S_FINAL;
      end
      S_FINAL: begin
        chain_d = sum;
        for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = sum[i];
        if (m224_q) digest_d[31:0] = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // run_q gates acceptance until the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      st_q     <= '0;
      w_q      <= '0;
      init_q   <= '0;
      chain_q  <= to_words(IV256_FLAT);
      digest_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      m224_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      w_q      <= w_d;
      init_q   <= init_d;
      chain_q  <= chain_d;
      digest_q <= digest_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      m224_q   <= m224_d;
      run_q    <= run_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign digest = digest_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed bench for sha256_compress_core: UNROLL 1/2/4 instances, chaining, reset abort.
// Define SHA256_SHA224_EN for both RTL and bench to exercise the SHA-224 path.
module tb_sha256_compress_core;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_DG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_DG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  typedef struct {
    logic [511:0] blk;
    logic         fst;
    logic         poke;
    logic         chk_dg;
    logic [255:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] block;
  logic         first;
  logic         start_v  [3];
  logic         ready_v  [3];
  logic         done_v   [3];
  logic [255:0] digest_v [3];
`ifdef SHA256_SHA224_EN
  logic         mode224;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha256_compress_core #(.UNROLL(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .first(first), .block(block),
`ifdef SHA256_SHA224_EN
    .mode224(mode224),
`endif
    .ready(ready_v[0]), .done(done_v[0]), .digest(digest_v[0]));

  sha256_compress_core #(.UNROLL(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .first(first), .block(block),
`ifdef SHA256_SHA224_EN
    .mode224(mode224),
`endif
    .ready(ready_v[1]), .done(done_v[1]), .digest(digest_v[1]));

  sha256_compress_core #(.UNROLL(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .first(first), .block(block),
`ifdef SHA256_SHA224_EN
    .mode224(mode224),
`endif
    .ready(ready_v[2]), .done(done_v[2]), .digest(digest_v[2]));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one block on instance idx; lat = edges from acceptance to done.
  task automatic run_block(input int idx, input logic [511:0] blk, input logic fst,
                           input logic poke, output int lat);
    @(negedge clk);
    chk("ready_before_start", 256'(ready_v[idx]), 256'(1));
    block        = blk;
    first        = fst;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    start_v[idx] = 1'b0;
    block        = '1;
    first        = ~fst;
    lat          = 0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (poke && lat == 10) begin
        chk("ready_low_busy", 256'(ready_v[idx]), 256'(0));
        start_v[idx] = 1'b1;
        block        = EMPTY_BLK;
      end
      if (poke && lat == 13) start_v[idx] = 1'b0;
      if (done_v[idx]) break;
    end
    if (lat >= 300) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: inst %0d no done within %0d cycles", idx, lat);
    end
  endtask

  vec_t vecs [4];
  int   lat;

  initial begin
    vecs[0] = '{ABC_BLK,   1'b1, 1'b0, 1'b1, ABC_DG};
    vecs[1] = '{EMPTY_BLK, 1'b1, 1'b0, 1'b1, EMPTY_DG};
    vecs[2] = '{TWO_B1,    1'b1, 1'b1, 1'b0, 256'h0};
    vecs[3] = '{TWO_B2,    1'b0, 1'b0, 1'b1, TWO_DG};

    reset_n = 1'b0;
    block   = '0;
    first   = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
`ifdef SHA256_SHA224_EN
    mode224 = 1'b0;
`endif
    #12;
    chk("reset_ready",  256'(ready_v[0]), 256'(1));
    chk("reset_done",   256'(done_v[0]),  256'(0));
    chk("reset_digest", digest_v[0],     256'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back table on UNROLL=1; entry 2 pokes start while busy.
    for (int v = 0; v < 4; v++) begin
      run_block(0, vecs[v].blk, vecs[v].fst, vecs[v].poke, lat);
      chk($sformatf("latency_u1_vec%0d", v), 256'(lat), 256'(65));
      if (vecs[v].chk_dg) chk($sformatf("digest_u1_vec%0d", v), digest_v[0], vecs[v].exp);
    end
    @(posedge clk);
    #1;
    chk("done_single_cycle", 256'(done_v[0]), 256'(0));
    chk("digest_hold",       digest_v[0],     TWO_DG);

    run_block(1, ABC_BLK, 1'b1, 1'b0, lat);
    chk("latency_u2", 256'(lat), 256'(33));
    chk("digest_u2",  digest_v[1], ABC_DG);
    run_block(2, ABC_BLK, 1'b1, 1'b0, lat);
    chk("latency_u4", 256'(lat), 256'(17));
    chk("digest_u4",  digest_v[2], ABC_DG);

`ifdef SHA256_SHA224_EN
    mode224 = 1'b1;
    run_block(0, ABC_BLK, 1'b1, 1'b0, lat);
    mode224 = 1'b0;
    chk("latency_224", 256'(lat), 256'(65));
    chk("digest_224", digest_v[0],
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000);
`endif

    // Reset during round 30 aborts the block and restores the IV chain.
    @(negedge clk);
    block      = ABC_BLK;
    first      = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_done",   256'(done_v[0]),  256'(0));
    chk("abort_digest", digest_v[0],      256'h0);
    chk("abort_ready",  256'(ready_v[0]), 256'(1));
    repeat (2) @(posedge clk);
    #1;
    chk("abort_done_held", 256'(done_v[0]), 256'(0));
    @(negedge clk);
    reset_n    = 1'b1;
    block      = ABC_BLK;
    first      = 1'b0;
    start_v[0] = 1'b1;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) start_v[0] = 1'b0;
      if (done_v[0]) break;
    end
    chk("latency_after_reset", 256'(lat), 256'(67));
    chk("digest_after_reset",  digest_v[0], ABC_DG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
